cnn_line_buffer: RTL and testbench

- Parametrised, stall-capable row delay line for CNN window generation. Generalises the fixed-length layer shift chains: width, maximum row length and row-tap count are parameters; the active row length is runtime-configurable.
- Sits between the feature-map input stream and the KxK window/MAC stage. Provides NUM_ROWS taps; tap k is the input delayed by (k+1) rows.
- Tap outputs carry validity tracking. The block supports input stalls and a synchronous flush.

---
 rtl/cnn_line_buffer.sv | 111 +++++++++++
 tb/tb_cnn_line_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_line_buffer.sv
`default_nettype none
// ============================================================================
// cnn_line_buffer : stall-capable multi-row delay line feeding a KxK window
// Rev 1.0
// ============================================================================
module cnn_line_buffer #(
   parameter int DATA_W    = 128,
   parameter int MAX_DEPTH = 32,
   parameter int NUM_ROWS  = 2,
   parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic [DEPTH_W-1:0]           cfg_depth,
   input  logic                         in_valid,
   input  logic [DATA_W-1:0]            in_data,
   output logic [NUM_ROWS*DATA_W-1:0]   tap_data,
   output logic [NUM_ROWS-1:0]          tap_valid,
   output logic [DEPTH_W-1:0]           row_col,
   output logic                         row_done,
   output logic                         cfg_err
);

   localparam int c_FILL_W = DEPTH_W + $clog2(NUM_ROWS) + 1;
   localparam int c_IDX_W  = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

   logic [DATA_W-1:0]          r_ring [NUM_ROWS][MAX_DEPTH];
   logic [DEPTH_W-1:0]         r_col;
   logic [DEPTH_W-1:0]         r_depth;
   logic [c_FILL_W-1:0]        r_fill;
   logic [NUM_ROWS*DATA_W-1:0] r_tap_data;
   logic [NUM_ROWS-1:0]        r_tap_valid;
   logic                       r_row_done;
   logic                       r_cfg_err;

   logic [c_IDX_W-1:0]         w_idx;
   logic                       w_last;
   logic                       w_cfg_ok;
   logic [c_FILL_W-1:0]        w_depth_x;
   logic [c_FILL_W-1:0]        w_fill_max;
   logic [c_FILL_W-1:0]        w_fill_nxt;
   logic [NUM_ROWS-1:0]        w_thr_ok;

   assign w_idx      = r_col[c_IDX_W-1:0];
   assign w_last     = (r_col == (r_depth - DEPTH_W'(1)));
   assign w_cfg_ok   = (cfg_depth != '0) && (cfg_depth <= DEPTH_W'(MAX_DEPTH));
   assign w_depth_x  = c_FILL_W'(r_depth);
   assign w_fill_max = c_FILL_W'(NUM_ROWS) * w_depth_x;
   assign w_fill_nxt = (r_fill >= w_fill_max) ? w_fill_max : (r_fill + c_FILL_W'(1));

   // Tap k only carries real data once (k+1) full rows have passed since clear/reset.
   always_comb begin
      w_thr_ok = '0;
      for (int k = 0; k < NUM_ROWS; k++) begin
         w_thr_ok[k] = (r_fill >= (c_FILL_W'(k + 1) * w_depth_x));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_ROWS; k++) begin
            for (int d = 0; d < MAX_DEPTH; d++) begin
               r_ring[k][d] <= '0;
            end
         end
         r_col       <= '0;
         r_depth     <= DEPTH_W'(MAX_DEPTH);
         r_fill      <= '0;
         r_tap_data  <= '0;
         r_tap_valid <= '0;
         r_row_done  <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else if (clear) begin
         r_col       <= '0;
         r_fill      <= '0;
         r_tap_data  <= '0;
         r_tap_valid <= '0;
         r_row_done  <= 1'b0;
         if (w_cfg_ok) begin
            r_depth <= cfg_depth;
         end else begin
            r_depth   <= DEPTH_W'(MAX_DEPTH);
            r_cfg_err <= 1'b1;
         end
      end else if (in_valid) begin
         for (int k = 0; k < NUM_ROWS; k++) begin
            r_tap_data[k*DATA_W +: DATA_W] <= w_thr_ok[k] ? r_ring[k][w_idx] : '0;
         end
         // Each row ring hands its oldest element down to the next ring at the same column.
         r_ring[0][w_idx] <= in_data;
         for (int k = 1; k < NUM_ROWS; k++) begin
            r_ring[k][w_idx] <= r_ring[k-1][w_idx];
         end
         r_tap_valid <= w_thr_ok;
         r_col       <= w_last ? '0 : (r_col + DEPTH_W'(1));
         r_row_done  <= w_last;
         r_fill      <= w_fill_nxt;
      end else begin
         r_row_done <= 1'b0;
      end
   end

   assign tap_data  = r_tap_data;
   assign tap_valid = r_tap_valid;
   assign row_col   = r_col;
   assign row_done  = r_row_done;
   assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_cnn_line_buffer.sv
`default_nettype none
// ============================================================================
// tb_cnn_line_buffer : scoreboard bench for the row delay line
// Rev 1.0
// ============================================================================
module tb_cnn_line_buffer;

   localparam int DW   = 128;
   localparam int MD   = 32;
   localparam int ND   = 2;
   localparam int DEPW = 6;

   typedef struct {
      logic [ND*DW-1:0] td;
      logic [ND-1:0]    tv;
      logic [DEPW-1:0]  col;
      logic             done;
      logic             err;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clear = 1'b0;
   logic [DEPW-1:0]   cfg_depth = '0;
   logic              in_valid = 1'b0;
   logic [DW-1:0]     in_data = '0;
   logic [ND*DW-1:0]  tap_data;
   logic [ND-1:0]     tap_valid;
   logic [DEPW-1:0]   row_col;
   logic              row_done;
   logic              cfg_err;

   int n_vec = 0;
   int n_bad = 0;

   exp_t          sbq[$];
   exp_t          m;
   logic [DW-1:0] hist[$];
   int            m_depth;
   int            m_col;

   cnn_line_buffer #(.DATA_W(DW), .MAX_DEPTH(MD), .NUM_ROWS(ND), .DEPTH_W(DEPW)) dut (
      .clk(clk), .rst(rst), .clear(clear), .cfg_depth(cfg_depth),
      .in_valid(in_valid), .in_data(in_data), .tap_data(tap_data),
      .tap_valid(tap_valid), .row_col(row_col), .row_done(row_done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: one expectation per driven cycle, checked just after the edge.
   always @(posedge clk) begin
      #1;
      if (sbq.size() != 0) begin
         exp_t e;
         e = sbq.pop_front();
         chk("sb_tap0", tap_data[DW-1:0], e.td[DW-1:0]);
         chk("sb_tap1", tap_data[2*DW-1:DW], e.td[2*DW-1:DW]);
         chk("sb_valid", DW'(tap_valid), DW'(e.tv));
         chk("sb_col", DW'(row_col), DW'(e.col));
         chk("sb_done", DW'(row_done), DW'(e.done));
         chk("sb_err", DW'(cfg_err), DW'(e.err));
      end
   end

   task automatic m_reset();
      m.td = '0; m.tv = '0; m.col = '0; m.done = 1'b0; m.err = 1'b0;
      hist.delete();
      m_depth = MD;
      m_col   = 0;
   endtask

   // Reference: tap k after the N-th accept since clear is sample N-(k+1)*depth.
   task automatic drv(input logic v, input int d, input logic c, input int cfg);
      @(negedge clk);
      in_valid  = v;
      in_data   = DW'(d);
      clear     = c;
      cfg_depth = DEPW'(cfg);
      if (c) begin
         m.td = '0; m.tv = '0; m.col = '0; m.done = 1'b0;
         hist.delete();
         m_col = 0;
         if (cfg >= 1 && cfg <= MD) m_depth = cfg;
         else begin
            m_depth = MD;
            m.err   = 1'b1;
         end
      end else if (v) begin
         int n;
         hist.push_back(DW'(d));
         n = hist.size();
         for (int k = 0; k < ND; k++) begin
            int idx;
            idx = n - (k + 1) * m_depth;
            if (idx >= 1) begin
               m.td[k*DW +: DW] = hist[idx-1];
               m.tv[k]          = 1'b1;
            end else begin
               m.td[k*DW +: DW] = '0;
               m.tv[k]          = 1'b0;
            end
         end
         m.done = (m_col == m_depth - 1);
         m_col  = m.done ? 0 : m_col + 1;
         m.col  = DEPW'(m_col);
      end else begin
         m.done = 1'b0;
      end
      sbq.push_back(m);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_td"}, tap_data[DW-1:0] | tap_data[2*DW-1:DW], '0);
      chk({tag, "_tv"}, DW'(tap_valid), '0);
      chk({tag, "_col"}, DW'(row_col), '0);
      chk({tag, "_done"}, DW'(row_done), '0);
      chk({tag, "_err"}, DW'(cfg_err), '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Fill and delay at depth 4
      drv(0, 0, 1, 4);
      for (int i = 1; i <= 12; i++) begin
         drv(1, i, 0, 0);
         if (i == 4) begin settle(); chk("fd_done4", DW'(row_done), 1); end
         if (i == 5) begin settle(); chk("fd_v0", DW'(tap_valid[0]), 1); chk("fd_t0_5", tap_data[DW-1:0], 1); end
         if (i == 8) begin settle(); chk("fd_v1_8", DW'(tap_valid[1]), 0); end
         if (i == 9) begin settle(); chk("fd_v1_9", DW'(tap_valid[1]), 1); chk("fd_t1_9", tap_data[2*DW-1:DW], 1); end
         if (i == 12) begin
            settle();
            chk("fd_t0_12", tap_data[DW-1:0], 8);
            chk("fd_t1_12", tap_data[2*DW-1:DW], 4);
            chk("fd_done12", DW'(row_done), 1);
         end
      end

      // Stalls: pattern 1,0,0,1
      drv(0, 0, 1, 4);
      begin
         int acc = 0;
         int ph  = 0;
         while (acc < 12) begin
            if (ph == 0 || ph == 3) begin
               acc++;
               drv(1, acc, 0, 0);
            end else begin
               drv(0, 0, 0, 0);
            end
            ph = (ph + 1) % 4;
         end
      end

      // Clear mid-stream with a colliding sample
      drv(0, 0, 1, 4);
      for (int i = 1; i <= 7; i++) drv(1, i, 0, 0);
      drv(1, 99, 1, 4);
      settle();
      chk("clr_tv", DW'(tap_valid), 0);
      chk("clr_td", tap_data[DW-1:0] | tap_data[2*DW-1:DW], 0);
      chk("clr_col", DW'(row_col), 0);
      for (int i = 1; i <= 12; i++) drv(1, i, 0, 0);

      // Illegal configurations fall back to MAX_DEPTH
      drv(0, 0, 1, 0);
      settle();
      chk("ill_err0", DW'(cfg_err), 1);
      drv(0, 0, 1, MD + 1);
      for (int i = 1; i <= 40; i++) begin
         drv(1, 100 + i, 0, 0);
         if (i == 31) begin settle(); chk("ill_col31", DW'(row_col), 31); end
         if (i == 32) begin settle(); chk("ill_wrap", DW'(row_col), 0); chk("ill_v32", DW'(tap_valid[0]), 0); end
         if (i == 33) begin settle(); chk("ill_v33", DW'(tap_valid[0]), 1); chk("ill_t33", tap_data[DW-1:0], 101); end
      end
      chk("ill_err_sticky", DW'(cfg_err), 1);

      // Depth 1
      drv(0, 0, 1, 1);
      drv(1, 10, 0, 0);
      drv(1, 11, 0, 0);
      settle();
      chk("d1_t0_2", tap_data[DW-1:0], 10);
      chk("d1_v1_2", DW'(tap_valid[1]), 0);
      drv(1, 12, 0, 0);
      settle();
      chk("d1_t0_3", tap_data[DW-1:0], 11);
      chk("d1_t1_3", tap_data[2*DW-1:DW], 10);
      chk("d1_v_3", DW'(tap_valid), 3);

      // Async reset mid-stream (cfg_err is set at this point)
      drv(0, 0, 1, 4);
      for (int i = 1; i <= 6; i++) drv(1, i, 0, 0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_zero("areset");
      m_reset();
      in_valid = 1'b0;
      clear    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 34; i++) begin
         drv(1, 200 + i, 0, 0);
         if (i == 5) begin settle(); chk("ar_v5", DW'(tap_valid), 0); end
         if (i == 33) begin settle(); chk("ar_v33", DW'(tap_valid[0]), 1); chk("ar_t33", tap_data[DW-1:0], 201); end
      end

      repeat (3) drv(0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #2;
      chk("sb_drained", DW'(sbq.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
